// File: rtl/outmem_reader_if.sv
`default_nettype none
// ============================================================================
// Module      : outmem_reader_if
// Description : Bundles the two buses of the output-memory reader.
//               - Read bus to the layer output memory:
//                 rd_en, rd_index2/1/0 (channel/row/column), mem_read_data
//               - Activation stream to the host:
//                 out_data, out_index2/1/0, out_last, out_valid, out_ready
//               master : the reader (drives reads and the stream)
//               slave  : memory + host side (returns data, drives out_ready)
// Revision    : 1.0 - initial release
// ============================================================================
interface outmem_reader_if #(
    parameter int DATA_SIZE = 64
);
    logic                 rd_en;
    logic [15:0]          rd_index2;
    logic [15:0]          rd_index1;
    logic [15:0]          rd_index0;
    logic [DATA_SIZE-1:0] mem_read_data;

    logic [DATA_SIZE-1:0] out_data;
    logic [15:0]          out_index2;
    logic [15:0]          out_index1;
    logic [15:0]          out_index0;
    logic                 out_last;
    logic                 out_valid;
    logic                 out_ready;

    modport master (
        output rd_en, rd_index2, rd_index1, rd_index0,
        input  mem_read_data,
        output out_data, out_index2, out_index1, out_index0,
        output out_last, out_valid,
        input  out_ready
    );

    modport slave (
        input  rd_en, rd_index2, rd_index1, rd_index0,
        output mem_read_data,
        input  out_data, out_index2, out_index1, out_index0,
        input  out_last, out_valid,
        output out_ready
    );
endinterface
`default_nettype wire

// File: rtl/outmem_reader.sv
`default_nettype none
// ============================================================================
// Module      : outmem_reader
// Description : Drains a layer's output activation memory to the host.
//               Walks channel/row/column, issues reads to the output memory,
//               absorbs the fixed read latency in a credit-controlled FIFO and
//               presents each word with its coordinates on a valid/ready
//               stream.
// Ports       : clk   - rising-edge clock
//               reset - asynchronous active-low reset
//               start - one-cycle pulse, begins a drain when idle
//               busy  - drain in progress
//               done  - one-cycle pulse after the last beat is accepted
//               bus   - read bus + output stream (outmem_reader_if.master)
// Revision    : 1.0 - initial release
// ============================================================================
module outmem_reader #(
    parameter int DATA_SIZE    = 64,
    parameter int NUM_CH       = 16,
    parameter int DIM          = 13,
    parameter int READ_LATENCY = 1,
    parameter int FIFO_DEPTH   = 4
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            start,
    output logic            busy,
    output logic            done,
    outmem_reader_if.master bus
);

    localparam logic [1:0] c_S_IDLE   = 2'd0;
    localparam logic [1:0] c_S_ISSUE  = 2'd1;
    localparam logic [1:0] c_S_DRAIN  = 2'd2;
    localparam logic [1:0] c_S_FINISH = 2'd3;

    localparam int c_CNT_W = $clog2(FIFO_DEPTH + 1);
    localparam int c_PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam logic [c_CNT_W:0]   c_DEPTH    = (c_CNT_W + 1)'(FIFO_DEPTH);
    localparam logic [c_PTR_W-1:0] c_PTR_LAST = c_PTR_W'(FIFO_DEPTH - 1);
    localparam logic [15:0]        c_LAST_CH  = 16'(NUM_CH - 1);
    localparam logic [15:0]        c_LAST_POS = 16'(DIM - 1);

    logic [1:0]          r_state;
    logic [15:0]         r_ch, r_row, r_col;
    logic [c_CNT_W-1:0]  r_inflight;
    logic [c_CNT_W-1:0]  r_count;
    logic [c_PTR_W-1:0]  r_wr_ptr, r_rd_ptr;

    // Read pipeline: tags travelling alongside each outstanding read
    logic                 r_pv [READ_LATENCY];
    logic [15:0]          r_p2 [READ_LATENCY];
    logic [15:0]          r_p1 [READ_LATENCY];
    logic [15:0]          r_p0 [READ_LATENCY];
    logic                 r_pl [READ_LATENCY];

    // Output FIFO storage
    logic [DATA_SIZE-1:0] r_fd [FIFO_DEPTH];
    logic [15:0]          r_f2 [FIFO_DEPTH];
    logic [15:0]          r_f1 [FIFO_DEPTH];
    logic [15:0]          r_f0 [FIFO_DEPTH];
    logic                 r_fl [FIFO_DEPTH];

    logic                 w_issue, w_push, w_pop, w_is_last, w_drained;
    logic [c_CNT_W:0]     w_used;

    assign w_pop     = bus.out_valid & bus.out_ready;
    assign w_push    = r_pv[READ_LATENCY-1];
    assign w_is_last = (r_ch == c_LAST_CH) && (r_row == c_LAST_POS) && (r_col == c_LAST_POS);

    // Credits: FIFO occupancy plus reads still in flight. A beat leaving the
    // FIFO this cycle frees its slot already, which keeps the stream gapless
    // when FIFO_DEPTH == READ_LATENCY+1. Invariant count+inflight <= depth
    // holds, so the FIFO is never written while full.
    assign w_used  = {1'b0, r_count} + {1'b0, r_inflight} - {{c_CNT_W{1'b0}}, w_pop};
    assign w_issue = (r_state == c_S_ISSUE) && (w_used < c_DEPTH);

    // The final beat may be leaving this very cycle; this lets done follow
    // the out_last handshake by exactly one cycle.
    assign w_drained = (r_inflight == '0) &&
                       ((r_count == '0) || ((r_count == c_CNT_W'(1)) && w_pop));

    assign busy = (r_state == c_S_ISSUE) || (r_state == c_S_DRAIN);
    assign done = (r_state == c_S_FINISH);

    assign bus.rd_en      = w_issue;
    assign bus.rd_index2  = r_ch;
    assign bus.rd_index1  = r_row;
    assign bus.rd_index0  = r_col;
    assign bus.out_valid  = (r_count != '0);
    assign bus.out_data   = r_fd[r_rd_ptr];
    assign bus.out_index2 = r_f2[r_rd_ptr];
    assign bus.out_index1 = r_f1[r_rd_ptr];
    assign bus.out_index0 = r_f0[r_rd_ptr];
    assign bus.out_last   = r_fl[r_rd_ptr];

    // Control FSM and channel/row/column walk
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state <= c_S_IDLE;
            r_ch    <= '0;
            r_row   <= '0;
            r_col   <= '0;
        end else begin
            case (r_state)
                c_S_IDLE: begin
                    if (start) begin
                        r_state <= c_S_ISSUE;
                        r_ch    <= '0;
                        r_row   <= '0;
                        r_col   <= '0;
                    end
                end
                c_S_ISSUE: begin
                    if (w_issue) begin
                        if (w_is_last) begin
                            r_state <= c_S_DRAIN;
                            r_ch    <= '0;
                            r_row   <= '0;
                            r_col   <= '0;
                        end else if (r_col == c_LAST_POS) begin
                            r_col <= '0;
                            if (r_row == c_LAST_POS) begin
                                r_row <= '0;
                                r_ch  <= r_ch + 16'd1;
                            end else begin
                                r_row <= r_row + 16'd1;
                            end
                        end else begin
                            r_col <= r_col + 16'd1;
                        end
                    end
                end
                c_S_DRAIN: begin
                    if (w_drained) r_state <= c_S_FINISH;
                end
                c_S_FINISH: r_state <= c_S_IDLE;
                default:    r_state <= c_S_IDLE;
            endcase
        end
    end

    // Read pipeline matching the memory latency
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < READ_LATENCY; i++) begin
                r_pv[i] <= 1'b0;
                r_p2[i] <= '0;
                r_p1[i] <= '0;
                r_p0[i] <= '0;
                r_pl[i] <= 1'b0;
            end
            r_inflight <= '0;
        end else begin
            r_pv[0] <= w_issue;
            r_p2[0] <= r_ch;
            r_p1[0] <= r_row;
            r_p0[0] <= r_col;
            r_pl[0] <= w_is_last;
            for (int i = 1; i < READ_LATENCY; i++) begin
                r_pv[i] <= r_pv[i-1];
                r_p2[i] <= r_p2[i-1];
                r_p1[i] <= r_p1[i-1];
                r_p0[i] <= r_p0[i-1];
                r_pl[i] <= r_pl[i-1];
            end
            r_inflight <= r_inflight + c_CNT_W'(w_issue) - c_CNT_W'(w_push);
        end
    end

    // Output FIFO
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < FIFO_DEPTH; i++) begin
                r_fd[i] <= '0;
                r_f2[i] <= '0;
                r_f1[i] <= '0;
                r_f0[i] <= '0;
                r_fl[i] <= 1'b0;
            end
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) begin
                r_fd[r_wr_ptr] <= bus.mem_read_data;
                r_f2[r_wr_ptr] <= r_p2[READ_LATENCY-1];
                r_f1[r_wr_ptr] <= r_p1[READ_LATENCY-1];
                r_f0[r_wr_ptr] <= r_p0[READ_LATENCY-1];
                r_fl[r_wr_ptr] <= r_pl[READ_LATENCY-1];
                r_wr_ptr <= (r_wr_ptr == c_PTR_LAST) ? '0 : r_wr_ptr + c_PTR_W'(1);
            end
            if (w_pop) begin
                r_rd_ptr <= (r_rd_ptr == c_PTR_LAST) ? '0 : r_rd_ptr + c_PTR_W'(1);
            end
            r_count <= r_count + c_CNT_W'(w_push) - c_CNT_W'(w_pop);
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_outmem_reader.sv
`default_nettype none
// ============================================================================
// Module      : tb_outmem_reader
// Description : Self-checking bench for outmem_reader. Two instances share one
//               clock: dut0 (READ_LATENCY=1) and dut1 (READ_LATENCY=3), both
//               NUM_CH=2, DIM=3, FIFO_DEPTH=4, memory data ch*100+row*10+col.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_outmem_reader;

    localparam int TB_CH    = 2;
    localparam int TB_DIM   = 3;
    localparam int TB_BEATS = TB_CH * TB_DIM * TB_DIM;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic reset;
    logic start0, start1;
    logic busy0, busy1, done0, done1;

    outmem_reader_if #(.DATA_SIZE(64)) bus0 ();
    outmem_reader_if #(.DATA_SIZE(64)) bus1 ();

    outmem_reader #(
        .DATA_SIZE(64), .NUM_CH(TB_CH), .DIM(TB_DIM), .READ_LATENCY(1), .FIFO_DEPTH(4)
    ) u_dut0 (
        .clk(clk), .reset(reset), .start(start0), .busy(busy0), .done(done0), .bus(bus0)
    );

    outmem_reader #(
        .DATA_SIZE(64), .NUM_CH(TB_CH), .DIM(TB_DIM), .READ_LATENCY(3), .FIFO_DEPTH(4)
    ) u_dut1 (
        .clk(clk), .reset(reset), .start(start1), .busy(busy1), .done(done1), .bus(bus1)
    );

    function automatic logic [63:0] mem_val(input logic [15:0] c, input logic [15:0] r,
                                            input logic [15:0] k);
        return 64'(c) * 64'd100 + 64'(r) * 64'd10 + 64'(k);
    endfunction

    // Memory models: fixed read latency, garbage when no read was issued
    logic [63:0] m0_q;
    logic [63:0] m1_q [3];
    always @(posedge clk) begin
        m0_q    <= bus0.rd_en ? mem_val(bus0.rd_index2, bus0.rd_index1, bus0.rd_index0)
                              : 64'hBAD0_BAD0_BAD0_BAD0;
        m1_q[0] <= bus1.rd_en ? mem_val(bus1.rd_index2, bus1.rd_index1, bus1.rd_index0)
                              : 64'hBAD1_BAD1_BAD1_BAD1;
        m1_q[1] <= m1_q[0];
        m1_q[2] <= m1_q[1];
    end
    assign bus0.mem_read_data = m0_q;
    assign bus1.mem_read_data = m1_q[2];

    // ------------------------------------------------------------------
    // Checking state
    // ------------------------------------------------------------------
    int tests = 0;
    int fails = 0;
    int cyc   = 0;

    int  rl        [2] = '{1, 3};
    int  exp_n     [2];
    int  done_due  [2];
    int  start_cyc [2];
    int  beats     [2];
    int  dones     [2];
    int  first_hs  [2];
    int  last_hs   [2];
    int  issues    [2];
    bit  m_active  [2];
    bit  first_seen[2];
    bit  p_stall   [2];
    logic [63:0] p_data [2];
    logic [15:0] p_i2 [2], p_i1 [2], p_i0 [2];
    logic        p_last [2];
    logic [63:0] got [2][TB_BEATS];

    logic        s_v [2], s_rdy [2], s_lst [2], s_bsy [2], s_dn [2], s_rde [2], s_st [2];
    logic [63:0] s_d [2];
    logic [15:0] s_i2 [2], s_i1 [2], s_i0 [2];
    bit          s_act, s_exp_done;
    int          s_n;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // ------------------------------------------------------------------
    // Compare process: model of the beat sequence, busy/done and stalls
    // ------------------------------------------------------------------
    always @(negedge clk) begin : p_compare
        cyc++;
        s_v[0] = bus0.out_valid;  s_v[1] = bus1.out_valid;
        s_rdy[0] = bus0.out_ready; s_rdy[1] = bus1.out_ready;
        s_lst[0] = bus0.out_last; s_lst[1] = bus1.out_last;
        s_d[0] = bus0.out_data;   s_d[1] = bus1.out_data;
        s_i2[0] = bus0.out_index2; s_i2[1] = bus1.out_index2;
        s_i1[0] = bus0.out_index1; s_i1[1] = bus1.out_index1;
        s_i0[0] = bus0.out_index0; s_i0[1] = bus1.out_index0;
        s_bsy[0] = busy0; s_bsy[1] = busy1;
        s_dn[0] = done0;  s_dn[1] = done1;
        s_rde[0] = bus0.rd_en; s_rde[1] = bus1.rd_en;
        s_st[0] = start0; s_st[1] = start1;

        for (int k = 0; k < 2; k++) begin
            if (!reset) begin
                chk($sformatf("dut%0d out_valid in reset", k), 64'(s_v[k]), 64'd0);
                chk($sformatf("dut%0d out_data in reset", k), s_d[k], 64'd0);
                chk($sformatf("dut%0d busy in reset", k), 64'(s_bsy[k]), 64'd0);
                chk($sformatf("dut%0d rd_en in reset", k), 64'(s_rde[k]), 64'd0);
                m_active[k]   = 1'b0;
                done_due[k]   = -1;
                exp_n[k]      = 0;
                first_seen[k] = 1'b1;
                p_stall[k]    = 1'b0;
            end else begin
                s_act      = m_active[k];
                s_exp_done = (cyc == done_due[k]);
                chk($sformatf("dut%0d busy", k), 64'(s_bsy[k]), 64'(s_act));
                chk($sformatf("dut%0d done", k), 64'(s_dn[k]), 64'(s_exp_done));
                if (s_exp_done) done_due[k] = -1;
                if (s_dn[k]) dones[k]++;

                if (p_stall[k]) begin
                    chk($sformatf("dut%0d held valid", k), 64'(s_v[k]), 64'd1);
                    chk($sformatf("dut%0d held data", k), s_d[k], p_data[k]);
                    chk($sformatf("dut%0d held index", k), {16'd0, s_i2[k], s_i1[k], s_i0[k]},
                        {16'd0, p_i2[k], p_i1[k], p_i0[k]});
                    chk($sformatf("dut%0d held last", k), 64'(s_lst[k]), 64'(p_last[k]));
                end

                if (s_v[k] && !first_seen[k]) begin
                    first_seen[k] = 1'b1;
                    chk($sformatf("dut%0d first out_valid cycle", k), 64'(cyc),
                        64'(start_cyc[k] + rl[k] + 2));
                end

                if (s_rde[k]) issues[k]++;

                if (s_v[k] && s_rdy[k]) begin
                    s_n = exp_n[k];
                    if (s_n >= TB_BEATS) begin
                        chk($sformatf("dut%0d extra beat", k), 64'(s_n), 64'(TB_BEATS - 1));
                    end else begin
                        chk($sformatf("dut%0d beat %0d data", k, s_n), s_d[k],
                            mem_val(16'(s_n / (TB_DIM * TB_DIM)), 16'((s_n / TB_DIM) % TB_DIM),
                                    16'(s_n % TB_DIM)));
                        chk($sformatf("dut%0d beat %0d index", k, s_n),
                            {16'd0, s_i2[k], s_i1[k], s_i0[k]},
                            {16'd0, 16'(s_n / (TB_DIM * TB_DIM)), 16'((s_n / TB_DIM) % TB_DIM),
                             16'(s_n % TB_DIM)});
                        chk($sformatf("dut%0d beat %0d last", k, s_n), 64'(s_lst[k]),
                            64'(s_n == TB_BEATS - 1));
                        got[k][s_n] = s_d[k];
                        if (s_n == 0) first_hs[k] = cyc;
                        last_hs[k] = cyc;
                        beats[k]++;
                        if (s_n == TB_BEATS - 1) begin
                            done_due[k] = cyc + 1;
                            m_active[k] = 1'b0;
                        end
                    end
                    exp_n[k]++;
                end

                p_stall[k] = s_v[k] && !s_rdy[k];
                p_data[k]  = s_d[k];
                p_i2[k] = s_i2[k]; p_i1[k] = s_i1[k]; p_i0[k] = s_i0[k];
                p_last[k]  = s_lst[k];

                if (s_st[k] && !s_act && !s_exp_done) begin
                    m_active[k]   = 1'b1;
                    start_cyc[k]  = cyc;
                    exp_n[k]      = 0;
                    first_seen[k] = 1'b0;
                    issues[k]     = 0;
                end
            end
        end

        // The FIFO must never be written while full
        chk("dut0 fifo write when full", 64'(u_dut0.w_push && (int'(u_dut0.r_count) == 4)), 64'd0);
        chk("dut1 fifo write when full", 64'(u_dut1.w_push && (int'(u_dut1.r_count) == 4)), 64'd0);
    end

    // ------------------------------------------------------------------
    // Stimulus helpers
    // ------------------------------------------------------------------
    task automatic pulse_start(input int k);
        if (k == 0) start0 = 1'b1; else start1 = 1'b1;
        @(posedge clk); #1;
        start0 = 1'b0;
        start1 = 1'b0;
    endtask

    task automatic wait_done(input int k, input int budget);
        int d0 = dones[k];
        int i  = 0;
        while (dones[k] == d0 && i < budget) begin
            @(posedge clk); #1;
            i++;
        end
        chk($sformatf("dut%0d done within budget", k), 64'(dones[k] != d0), 64'd1);
    endtask

    task automatic wait_beats(input int k, input int n, input int budget);
        int i = 0;
        while (beats[k] < n && i < budget) begin
            @(posedge clk); #1;
            i++;
        end
        chk($sformatf("dut%0d %0d beats within budget", k, n), 64'(beats[k] >= n), 64'd1);
    endtask

    int d;

    initial begin
        done_due[0] = -1;
        done_due[1] = -1;
        reset  = 1'b0;
        start0 = 1'b0;
        start1 = 1'b0;
        bus0.out_ready = 1'b1;
        bus1.out_ready = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        chk("reset busy", 64'(busy0), 64'd0);
        chk("reset done", 64'(done0), 64'd0);
        chk("reset out_valid", 64'(bus0.out_valid), 64'd0);
        chk("reset out_last", 64'(bus0.out_last), 64'd0);
        chk("reset rd_index", {16'd0, bus0.rd_index2, bus0.rd_index1, bus0.rd_index0}, 64'd0);
        reset = 1'b1;
        repeat (2) @(posedge clk);
        #1;

        // Full-rate drain
        beats[0] = 0;
        pulse_start(0);
        wait_done(0, 100);
        chk("full beats", 64'(beats[0]), 64'd18);
        chk("full span", 64'(last_hs[0] - first_hs[0]), 64'd17);
        chk("full beat0", got[0][0], 64'd0);
        chk("full beat2", got[0][2], 64'd2);
        chk("full beat3", got[0][3], 64'd10);
        chk("full beat9", got[0][9], 64'd100);
        chk("full beat17", got[0][17], 64'd122);
        repeat (3) @(posedge clk);
        #1;

        // start pulsed while busy is ignored
        beats[0] = 0;
        d = dones[0];
        pulse_start(0);
        repeat (4) @(posedge clk);
        #1;
        pulse_start(0);
        wait_done(0, 100);
        repeat (40) @(posedge clk);
        #1;
        chk("restart done count", 64'(dones[0] - d), 64'd1);
        chk("restart beats", 64'(beats[0]), 64'd18);

        // Backpressure
        bus0.out_ready = 1'b0;
        beats[0] = 0;
        pulse_start(0);
        repeat (10) @(posedge clk);
        #1;
        chk("bp reads issued", 64'(issues[0]), 64'd4);
        chk("bp out_valid", 64'(bus0.out_valid), 64'd1);
        chk("bp out_data", bus0.out_data, 64'd0);
        chk("bp beats", 64'(beats[0]), 64'd0);
        bus0.out_ready = 1'b1;
        wait_done(0, 100);
        chk("bp total beats", 64'(beats[0]), 64'd18);
        chk("bp span", 64'(last_hs[0] - first_hs[0]), 64'd17);
        chk("bp beat17", got[0][17], 64'd122);
        repeat (3) @(posedge clk);
        #1;

        // Random out_ready
        beats[0] = 0;
        d = dones[0];
        pulse_start(0);
        for (int i = 0; i < 300 && dones[0] == d; i++) begin
            bus0.out_ready = 1'($urandom_range(0, 1));
            @(posedge clk); #1;
        end
        bus0.out_ready = 1'b1;
        chk("rand done", 64'(dones[0] - d), 64'd1);
        chk("rand beats", 64'(beats[0]), 64'd18);
        repeat (3) @(posedge clk);
        #1;

        // Reset in the middle of a drain
        beats[0] = 0;
        d = dones[0];
        pulse_start(0);
        wait_beats(0, 5, 50);
        #2 reset = 1'b0;
        #1;
        chk("mid-reset busy", 64'(busy0), 64'd0);
        chk("mid-reset done", 64'(done0), 64'd0);
        chk("mid-reset out_valid", 64'(bus0.out_valid), 64'd0);
        chk("mid-reset out_data", bus0.out_data, 64'd0);
        chk("mid-reset out_index", {16'd0, bus0.out_index2, bus0.out_index1, bus0.out_index0}, 64'd0);
        chk("mid-reset out_last", 64'(bus0.out_last), 64'd0);
        chk("mid-reset rd_en", 64'(bus0.rd_en), 64'd0);
        @(posedge clk); #1;
        reset = 1'b1;
        repeat (30) @(posedge clk);
        #1;
        chk("mid-reset no done", 64'(dones[0] - d), 64'd0);
        beats[0] = 0;
        pulse_start(0);
        wait_done(0, 100);
        chk("post-reset beats", 64'(beats[0]), 64'd18);
        chk("post-reset beat0", got[0][0], 64'd0);
        chk("post-reset beat17", got[0][17], 64'd122);

        // READ_LATENCY=3 instance
        beats[1] = 0;
        pulse_start(1);
        wait_done(1, 100);
        chk("rl3 beats", 64'(beats[1]), 64'd18);
        chk("rl3 span", 64'(last_hs[1] - first_hs[1]), 64'd17);
        chk("rl3 beat4", got[1][4], 64'd11);
        chk("rl3 beat17", got[1][17], 64'd122);
        repeat (3) @(posedge clk);
        #1;

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, %0d failed so far", fails);
        $fatal(1);
    end

endmodule
`default_nettype wire
